// File: rtl/cv32e40p_x_outstanding_tracker.sv
// Offloaded-instruction tracker for the CORE-V-XIF interface: allocates IDs and follows each
// entry from issue acceptance to kill or result, and drives the rd busy scoreboards.
module cv32e40p_x_outstanding_tracker #(
    parameter int X_ID_WIDTH  = 4,
    parameter bit X_DUALWRITE = 1'b1,
    parameter bit X_FLOAT     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid_i,
    input  logic                  issue_ready_i,
    input  logic                  issue_accept_i,
    input  logic                  issue_writeback_i,
    input  logic                  issue_float_i,
    input  logic                  issue_dualwrite_i,
    input  logic [4:0]            issue_rd_i,
    output logic [X_ID_WIDTH-1:0] issue_id_o,
    output logic                  issue_alloc_ok_o,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    input  logic                  result_valid_i,
    input  logic [X_ID_WIDTH-1:0] result_id_i,
    input  logic [4:0]            result_rd_i,
    input  logic                  result_we_i,
    output logic [31:0]           gpr_busy_o,
    output logic [31:0]           fpr_busy_o,
    output logic [X_ID_WIDTH:0]   outstanding_cnt_o,
    output logic                  protocol_err_o
);

    localparam int DEPTH = 2 ** X_ID_WIDTH;
    localparam int CW    = X_ID_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_SPEC      = 2'd1,
        ST_COMMITTED = 2'd2
    } entry_state_e;

    entry_state_e state_q [DEPTH];
    entry_state_e state_d [DEPTH];
    logic         wb_q    [DEPTH];
    logic         fl_q    [DEPTH];
    logic         dual_q  [DEPTH];
    logic [4:0]   rd_q    [DEPTH];
    logic         err_q, err_d;
    logic         alloc;

    function automatic logic [4:0] rd_succ(input logic [4:0] rd);
        return rd + 5'd1;
    endfunction

    always_comb begin
        issue_id_o       = '0;
        issue_alloc_ok_o = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (state_q[i] == ST_FREE) begin
                issue_id_o       = X_ID_WIDTH'(i);
                issue_alloc_ok_o = 1'b1;
            end
        end
    end

    assign alloc = issue_valid_i & issue_ready_i & issue_accept_i & issue_alloc_ok_o;

    // Commit is applied before result so a same-cycle commit+result frees the entry at once.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        if (commit_valid_i) begin
            if (state_q[commit_id_i] == ST_SPEC) begin
                state_d[commit_id_i] = (commit_kill_i || !wb_q[commit_id_i]) ? ST_FREE : ST_COMMITTED;
            end else begin
                err_d = 1'b1;
            end
        end
        if (result_valid_i) begin
            if (state_d[result_id_i] == ST_COMMITTED) begin
                state_d[result_id_i] = ST_FREE;
                if (result_we_i != wb_q[result_id_i]) begin
                    err_d = 1'b1;
                end else if (wb_q[result_id_i] && (result_rd_i != rd_q[result_id_i]) &&
                             (!dual_q[result_id_i] || (result_rd_i != rd_succ(rd_q[result_id_i])))) begin
                    err_d = 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
        if (alloc) begin
            state_d[issue_id_o] = ST_SPEC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_FREE;
            end
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Payload fields are only meaningful while the entry is non-FREE, so they need no reset.
    always_ff @(posedge clk) begin
        if (alloc) begin
            wb_q[issue_id_o]   <= issue_writeback_i;
            fl_q[issue_id_o]   <= X_FLOAT & issue_float_i;
            dual_q[issue_id_o] <= X_DUALWRITE & issue_dualwrite_i;
            rd_q[issue_id_o]   <= issue_rd_i;
        end
    end

    always_comb begin
        gpr_busy_o        = '0;
        fpr_busy_o        = '0;
        outstanding_cnt_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] != ST_FREE) begin
                outstanding_cnt_o = outstanding_cnt_o + CW'(1);
                if (wb_q[i] && fl_q[i]) begin
                    fpr_busy_o[rd_q[i]] = 1'b1;
                    if (dual_q[i]) fpr_busy_o[rd_succ(rd_q[i])] = 1'b1;
                end else if (wb_q[i]) begin
                    gpr_busy_o[rd_q[i]] = 1'b1;
                    if (dual_q[i]) gpr_busy_o[rd_succ(rd_q[i])] = 1'b1;
                end
            end
        end
        gpr_busy_o[0] = 1'b0;
    end

    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_cv32e40p_x_outstanding_tracker.sv
// Directed and randomized bench for the XIF outstanding tracker against a table-based model.
module tb_cv32e40p_x_outstanding_tracker;

    localparam int W     = 4;
    localparam int DEPTH = 2 ** W;
    localparam int S_FREE = 0, S_SPEC = 1, S_DONE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         issue_valid, issue_ready, issue_accept, issue_wb, issue_fl, issue_dual;
    logic [4:0]   issue_rd;
    logic [W-1:0] issue_id;
    logic         alloc_ok;
    logic         commit_valid, commit_kill;
    logic [W-1:0] commit_id;
    logic         result_valid, result_we;
    logic [W-1:0] result_id;
    logic [4:0]   result_rd;
    logic [31:0]  gpr_busy, fpr_busy;
    logic [W:0]   cnt;
    logic         perr;

    cv32e40p_x_outstanding_tracker #(.X_ID_WIDTH(W), .X_DUALWRITE(1'b1), .X_FLOAT(1'b1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .issue_valid_i     (issue_valid),
        .issue_ready_i     (issue_ready),
        .issue_accept_i    (issue_accept),
        .issue_writeback_i (issue_wb),
        .issue_float_i     (issue_fl),
        .issue_dualwrite_i (issue_dual),
        .issue_rd_i        (issue_rd),
        .issue_id_o        (issue_id),
        .issue_alloc_ok_o  (alloc_ok),
        .commit_valid_i    (commit_valid),
        .commit_id_i       (commit_id),
        .commit_kill_i     (commit_kill),
        .result_valid_i    (result_valid),
        .result_id_i       (result_id),
        .result_rd_i       (result_rd),
        .result_we_i       (result_we),
        .gpr_busy_o        (gpr_busy),
        .fpr_busy_o        (fpr_busy),
        .outstanding_cnt_o (cnt),
        .protocol_err_o    (perr)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: one record per ID, plus the expected error pulse.
    int m_st   [DEPTH];
    bit m_wb   [DEPTH];
    bit m_fl   [DEPTH];
    bit m_dual [DEPTH];
    int m_rd   [DEPTH];
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int m_free();
        for (int e = 0; e < DEPTH; e++) if (m_st[e] == S_FREE) return e;
        return -1;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int e = 0; e < DEPTH; e++) if (m_st[e] != S_FREE) n++;
        return n;
    endfunction

    function automatic logic [31:0] m_busy(input bit want_fl);
        logic [31:0] b = '0;
        for (int r = 0; r < 32; r++)
            for (int e = 0; e < DEPTH; e++)
                if (m_st[e] != S_FREE && m_wb[e] && m_fl[e] == want_fl &&
                    (m_rd[e] == r || (m_dual[e] && (m_rd[e] + 1) % 32 == r)))
                    b[r] = 1'b1;
        if (!want_fl) b[0] = 1'b0;
        return b;
    endfunction

    task automatic m_clear();
        for (int e = 0; e < DEPTH; e++) m_st[e] = S_FREE;
        m_err = 1'b0;
    endtask

    task automatic m_update();
        int f = m_free();
        bit e = 1'b0;
        int c = int'(commit_id);
        int r = int'(result_id);
        if (commit_valid) begin
            if (m_st[c] == S_SPEC) m_st[c] = (commit_kill || !m_wb[c]) ? S_FREE : S_DONE;
            else e = 1'b1;
        end
        if (result_valid) begin
            if (m_st[r] == S_DONE) begin
                m_st[r] = S_FREE;
                if (result_we != m_wb[r]) e = 1'b1;
                else if (m_wb[r] && int'(result_rd) != m_rd[r] &&
                         !(m_dual[r] && int'(result_rd) == (m_rd[r] + 1) % 32)) e = 1'b1;
            end else begin
                e = 1'b1;
            end
        end
        if (issue_valid && issue_ready && issue_accept && f >= 0) begin
            m_st[f] = S_SPEC; m_wb[f] = issue_wb; m_fl[f] = issue_fl;
            m_dual[f] = issue_dual; m_rd[f] = int'(issue_rd);
        end
        m_err = e;
    endtask

    task automatic check_all();
        int f = m_free();
        chk("issue_id", 32'(issue_id), (f < 0) ? 32'd0 : 32'(f));
        chk("alloc_ok", 32'(alloc_ok), 32'(f >= 0));
        chk("gpr_busy", gpr_busy, m_busy(1'b0));
        chk("fpr_busy", fpr_busy, m_busy(1'b1));
        chk("cnt", 32'(cnt), 32'(m_count()));
        chk("perr", 32'(perr), 32'(m_err));
    endtask

    task automatic idle();
        issue_valid = 0; issue_ready = 0; issue_accept = 0; issue_wb = 0; issue_fl = 0;
        issue_dual = 0; issue_rd = '0; commit_valid = 0; commit_id = '0; commit_kill = 0;
        result_valid = 0; result_id = '0; result_rd = '0; result_we = 0;
    endtask

    task automatic step();
        m_update();
        @(posedge clk);
        #1;
        check_all();
        idle();
    endtask

    task automatic issue(input bit wb, input bit fl, input bit dual, input int rd);
        issue_valid = 1; issue_ready = 1; issue_accept = 1;
        issue_wb = wb; issue_fl = fl; issue_dual = dual; issue_rd = 5'(rd);
    endtask

    task automatic commit(input int id, input bit kill);
        commit_valid = 1; commit_id = W'(id); commit_kill = kill;
    endtask

    task automatic result(input int id, input int rd, input bit we);
        result_valid = 1; result_id = W'(id); result_rd = 5'(rd); result_we = we;
    endtask

    // Asserts rst_n between clock edges and checks the outputs before any edge arrives.
    task automatic do_reset();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        m_clear();
        chk("rst_id", 32'(issue_id), 32'd0);
        chk("rst_ok", 32'(alloc_ok), 32'd1);
        chk("rst_gpr", gpr_busy, 32'd0);
        chk("rst_fpr", fpr_busy, 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_perr", 32'(perr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        m_clear();
        #12;
        chk("init_ok", 32'(alloc_ok), 32'd1);
        chk("init_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        // Single issue / commit / result lifecycle
        issue(1, 0, 0, 5); step();
        chk("t1_id", 32'(issue_id), 32'd1);
        chk("t1_gpr", gpr_busy, 32'h20);
        chk("t1_cnt", 32'(cnt), 32'd1);
        commit(0, 0); step();
        result(0, 5, 1); step();
        chk("t1_gpr_clr", gpr_busy, 32'd0);
        chk("t1_cnt_clr", 32'(cnt), 32'd0);
        chk("t1_perr", 32'(perr), 32'd0);

        // Fill the table, then free id 7 by kill
        for (int i = 0; i < DEPTH; i++) begin
            issue(1, 0, 0, (i % 31) + 1); step();
        end
        chk("full_ok", 32'(alloc_ok), 32'd0);
        chk("full_cnt", 32'(cnt), 32'd16);
        chk("full_id", 32'(issue_id), 32'd0);
        commit(7, 1); step();
        chk("kill7_id", 32'(issue_id), 32'd7);
        chk("kill7_ok", 32'(alloc_ok), 32'd1);
        do_reset();

        // Dual-write scoreboards, including the rd+1 wrap onto x0
        issue(1, 1, 1, 4); step();
        chk("fdual_fpr", fpr_busy, 32'h30);
        chk("fdual_gpr", gpr_busy, 32'd0);
        issue(1, 0, 1, 31); step();
        chk("idual_gpr", gpr_busy, 32'h8000_0000);
        issue(1, 0, 0, 10); step();
        issue(1, 0, 0, 11); step();
        commit(3, 0); result(3, 11, 1); step();
        chk("cr3_perr", 32'(perr), 32'd0);
        chk("cr3_id", 32'(issue_id), 32'd3);

        // Protocol violations
        result(2, 10, 1); step();
        chk("spec_res_perr", 32'(perr), 32'd1);
        chk("spec_res_busy", gpr_busy & 32'h400, 32'h400);
        step();
        chk("perr_pulse", 32'(perr), 32'd0);
        commit(9, 0); step();
        chk("free_cmt_perr", 32'(perr), 32'd1);

        // Asynchronous reset with five outstanding
        issue(0, 0, 0, 0); step();
        issue(0, 0, 0, 0); step();
        chk("pre_rst_cnt", 32'(cnt), 32'd5);
        do_reset();

        // Randomized traffic
        for (int it = 0; it < 3000; it++) begin
            int q[$];
            int id;
            issue_valid  = ($urandom % 4) != 0;
            issue_ready  = ($urandom % 4) != 0;
            issue_accept = ($urandom % 5) != 0;
            issue_wb     = ($urandom % 4) != 0;
            issue_fl     = $urandom % 2;
            issue_dual   = ($urandom % 3) == 0;
            issue_rd     = 5'($urandom % 32);

            q = {};
            for (int e = 0; e < DEPTH; e++) if (m_st[e] == S_SPEC) q.push_back(e);
            commit_valid = $urandom % 2;
            commit_kill  = ($urandom % 4) == 0;
            id = (q.size() > 0 && ($urandom % 8) != 0) ? q[$urandom % q.size()] : int'($urandom % DEPTH);
            commit_id = W'(id);

            q = {};
            for (int e = 0; e < DEPTH; e++) if (m_st[e] == S_DONE) q.push_back(e);
            result_valid = $urandom % 2;
            id = (q.size() > 0 && ($urandom % 8) != 0) ? q[$urandom % q.size()] : int'($urandom % DEPTH);
            result_id = W'(id);
            result_we = (($urandom % 10) != 0) ? m_wb[id] : 1'($urandom % 2);
            case ($urandom % 10)
                0:       result_rd = 5'($urandom % 32);
                1, 2:    result_rd = 5'((m_rd[id] + 1) % 32);
                default: result_rd = 5'(m_rd[id]);
            endcase
            step();
            if (($urandom % 400) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cv32e40p_x_outstanding_tracker.md
Name: cv32e40p_x_outstanding_tracker

Overview:
- Tracks every CORE-V-XIF instruction offloaded to the coprocessor from issue acceptance until commit-kill or result retirement.
- Allocates transaction IDs.
- Drives integer and float destination-register busy scoreboards used by the ID stage for hazard stalls.
- Detects protocol violations.
- Sits in the core between the ID-stage offload logic and the XIF issue, commit and result channels.

Parameters:
- X_ID_WIDTH, 4, ID width; the table holds DEPTH = 2**X_ID_WIDTH entries.
- X_DUALWRITE, 1, when 1, dual-write issues mark rd and rd+1 busy; when 0, the dualwrite input is ignored.
- X_FLOAT, 1, when 0, the float scoreboard is tied to 0 and the float input is ignored.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid_i  in  1  core presents an offload
- issue_ready_i  in  1  coprocessor issue ready
- issue_accept_i  in  1  coprocessor accepted the instruction
- issue_writeback_i  in  1  instruction will write a register
- issue_float_i  in  1  destination is an FPR
- issue_dualwrite_i  in  1  instruction writes rd and rd+1
- issue_rd_i  in  5  destination register
- issue_id_o  out  X_ID_WIDTH  ID to drive on the issue request
- issue_alloc_ok_o  out  1  a free entry exists; the core must gate issue_valid with it
- commit_valid_i  in  1  commit handshake
- commit_id_i  in  X_ID_WIDTH  committed ID
- commit_kill_i  in  1  kill instead of commit
- result_valid_i  in  1  result handshake (result_ready fixed 1)
- result_id_i  in  X_ID_WIDTH  result ID
- result_rd_i  in  5  result destination
- result_we_i  in  1  result writes a register
- gpr_busy_o  out  32  integer rd pending mask, bit 0 always 0
- fpr_busy_o  out  32  float rd pending mask
- outstanding_cnt_o  out  X_ID_WIDTH+1  non-FREE entry count
- protocol_err_o  out  1  one-cycle pulse on a violation

Behaviour:
- Reset (asynchronous): all entries FREE, so:
  - issue_id_o = 0, issue_alloc_ok_o = 1;
  - gpr_busy_o, fpr_busy_o = 0;
  - outstanding_cnt_o = 0;
  - protocol_err_o = 0.
  - Reset asserted mid-operation discards all entries; no result or commit is honoured afterwards for old IDs.
- Entry fields: state {FREE, SPEC, COMMITTED}, wb, float, dual, rd[4:0].
- issue_id_o: lowest-index FREE entry, combinational from the registered table. When the table is full, issue_alloc_ok_o = 0 and issue_id_o = 0.
- Allocate on issue_valid_i & issue_ready_i & issue_accept_i & issue_alloc_ok_o:
  - entry[issue_id_o] becomes SPEC and captures wb, float, dual and rd.
  - Registered, so it takes effect the next cycle.
  - A rejected handshake (accept = 0) allocates nothing.
- Commit on commit_valid_i:
  - SPEC entry with kill = 1: FREE.
  - SPEC entry with kill = 0 and wb = 1: COMMITTED.
  - SPEC entry with kill = 0 and wb = 0: FREE (no result expected).
  - Commit to a FREE or COMMITTED entry: protocol_err_o, no state change.
- Result on result_valid_i:
  - COMMITTED entry: FREE.
  - Also raise protocol_err_o if result_we_i != wb, or if wb = 1 and result_rd_i differs from the stored rd and (dual = 0 or result_rd_i != rd+1); the entry is still freed.
  - Result to a SPEC entry (not yet committed) or a FREE entry: protocol_err_o, no state change.
- Simultaneous events:
  - Commit and result to the same ID in one cycle: commit is applied first, then result. Commit kill = 0 with wb = 1 plus result gives FREE in one cycle; kill = 1 plus result gives FREE and protocol_err_o.
  - Issue allocation can never target an entry being committed or resulted, because allocation requires FREE in the registered state.
  - Issue, commit and result to three different IDs in one cycle are all applied.
- Freed entries are reusable from the next cycle; the lowest index is reallocated first (wrap-free).
- Scoreboards are combinational from the registered table, with no extra latency.
  - gpr_busy_o[r] = OR over non-FREE entries with wb & !float & (rd == r | (dual & rd+1 == r)), for r != 0. gpr_busy_o[0] is forced 0.
  - fpr_busy_o is the same using float = 1; f0 is valid.
  - rd+1 wraps 31 → 0 modulo 32; a gpr bit 0 produced by the wrap is still masked.
- outstanding_cnt_o is the population count of non-FREE entries; it equals DEPTH when full.
- protocol_err_o is registered and asserted the cycle after the offending handshake.

Test Plan:
- Reset, then issue with accept = 1, rd = 5, wb = 1 → next cycle: issue_id_o = 1, gpr_busy_o = 32'h20, outstanding_cnt_o = 1. Commit id 0 with kill = 0, then result id 0 with rd = 5, we = 1 → gpr_busy_o = 0, cnt = 0, no error.
- Issue 16 accepted instructions (X_ID_WIDTH = 4) → issue_alloc_ok_o = 0, cnt = 16. Free id 7 via commit kill → issue_id_o = 7, alloc_ok = 1.
- Float dualwrite issue with rd = 4 → fpr_busy_o = 32'h30 and gpr_busy_o = 0. Integer dualwrite with rd = 31 → gpr_busy_o = 32'h8000_0000.
- Commit (kill = 0) and result for id 3 in the same cycle, entry SPEC, wb = 1 → entry FREE next cycle, protocol_err_o = 0.
- Result for id 2 while SPEC → protocol_err_o pulses 1 cycle, entry stays SPEC. Commit to FREE id 9 → protocol_err_o pulses.
- Drop rst_n asynchronously with 5 entries outstanding → all outputs at reset values immediately; after release, issue_id_o = 0.
